mips_muldiv: RTL and testbench



---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mips_muldiv_if.sv | 34 +++
 rtl/mips_div_step.sv | 24 ++
 rtl/mips_muldiv.sv | 195 +++++++++++++++++++
 tb/tb_mips_muldiv.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the MIPS I multiply/divide unit
// and the CPU decoder that issues MULT/MULTU/DIV/DIVU and MTHI/MTLO/MFHI/MFLO.
package mips_pkg;

   // Operation selector driven by the CPU's EXEC states.
   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } muldiv_op_t;

   // Sequencer states of the iterative unit.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FIXUP = 2'd2
   } muldiv_state_t;

   // SPECIAL-opcode funct field values decoded by the CPU.
   localparam logic [5:0] FUNCT_MFHI  = 6'd16;
   localparam logic [5:0] FUNCT_MTHI  = 6'd17;
   localparam logic [5:0] FUNCT_MFLO  = 6'd18;
   localparam logic [5:0] FUNCT_MTLO  = 6'd19;
   localparam logic [5:0] FUNCT_MULT  = 6'd24;
   localparam logic [5:0] FUNCT_MULTU = 6'd25;
   localparam logic [5:0] FUNCT_DIV   = 6'd26;
   localparam logic [5:0] FUNCT_DIVU  = 6'd27;

   // True for DIV and DIVU.
   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // True for the two-complement variants MULT and DIV.
   function automatic logic op_is_signed(input muldiv_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: request/result bundle between the CPU (master) and the
// multiply/divide unit (slave). Clock and reset travel as plain ports.
interface mips_muldiv_if
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             start;
   muldiv_op_t       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // CPU side: issues operations and MTHI/MTLO, reads HI/LO.
   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, div_zero, hi, lo
   );

   // Unit side: owns HI/LO and the handshake outputs.
   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/mips_div_step.sv
// mips_div_step: one restoring-division step. Shifts the next dividend bit
// into the partial remainder and subtracts the divisor when it fits.
// Purely combinational; the caller sequences the steps.
module mips_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             bit_in,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;

   // Trial subtraction; the low WIDTH bits of the difference are exact
   // whenever the divisor fits, so only the comparison needs WIDTH+1 bits.
   always_comb begin
      shifted = {rem_in, bit_in};
      q_bit   = (shifted >= {1'b0, divisor});
      rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit owning the MIPS I HI/LO
// registers. MULT/MULTU use shift-add (LSB first), DIV/DIVU use restoring
// division (MSB first), one bit per cycle, on operand magnitudes; FIXUP
// applies the sign correction and writes HI/LO. Latency is WIDTH+1 cycles.
//
// Optional build macro MIPS_MULDIV_FAST_MULT_EN: multiplies bypass the
// sequencer and use a combinational WIDTH x WIDTH multiplier, writing HI/LO
// one edge after the start edge without raising busy. Divides are unchanged.
module mips_muldiv
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   mips_muldiv_if.slave bus
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // Sequencer and operand state.
   muldiv_state_t      state_q, state_d;
   muldiv_op_t         op_q;
   logic               neg_a_q, neg_b_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CW-1:0]      cnt_q;
   logic               fast_pend_q;

   // Architectural outputs.
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q, div_zero_q;

   // Combinational helpers.
   logic               start_signed;
   logic               fast_go;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [CW-1:0]      mul_idx;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;
   logic [2*WIDTH-1:0] mag_prod, res_prod;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               res_dz;

   // Single restoring-division step on the upper half of the accumulator.
   mips_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
      .divisor (b_q),
      .bit_in  (a_q[cnt_q]),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

`ifdef MIPS_MULDIV_FAST_MULT_EN
   // Multiplies skip the sequencer; their magnitudes are multiplied directly
   // in the cycle after the start edge.
   assign fast_go  = (state_q == ST_IDLE) && bus.start && !op_is_div(bus.op);
   assign mag_prod = fast_pend_q ? ({{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q})
                                 : acc_q;
`else
   // Every operation goes through the iterative sequencer.
   assign fast_go  = 1'b0;
   assign mag_prod = acc_q;
`endif

   // Operand magnitudes captured at the start edge; unsigned ops pass through.
   always_comb begin
      start_signed = op_is_signed(bus.op);
      a_mag        = (start_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag        = (start_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   end

   // Shift-add step: add the multiplicand when the current multiplier bit is set.
   always_comb begin
      mul_idx    = CNT_LAST - cnt_q;
      mul_addend = b_q[mul_idx] ? a_q : {WIDTH{1'b0}};
      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   end

   // Sign correction and divide-by-zero substitution for the HI/LO write.
   // NOTE: every output of a combinational block gets a default before any
   // condition; a path that leaves one unassigned infers a latch.
   always_comb begin
      res_prod = (neg_a_q ^ neg_b_q) ? -mag_prod : mag_prod;
      res_hi   = res_prod[2*WIDTH-1:WIDTH];
      res_lo   = res_prod[WIDTH-1:0];
      res_dz   = 1'b0;
      if (op_is_div(op_q)) begin
         if (b_q == '0) begin
            // Dividend is returned as originally presented (sign restored).
            res_lo = '1;
            res_hi = neg_a_q ? -a_q : a_q;
            res_dz = 1'b1;
         end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            res_lo = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            res_hi = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Next-state logic: IDLE -> RUN on an iterative start, RUN for WIDTH
   // cycles, one FIXUP cycle to write HI/LO.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start && !fast_go) state_d = ST_RUN;
         ST_RUN:   if (cnt_q == '0) state_d = ST_FIXUP;
         ST_FIXUP: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register.
   // NOTE: clocked blocks use non-blocking assignments only, so every register
   // samples the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Datapath, HI/LO and handshake pulses.
   // NOTE: the operand and accumulator registers are cleared by reset as well,
   // which keeps unknowns off the result path after a mid-operation reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q        <= OP_MULT;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         fast_pend_q <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         fast_pend_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A pending fast multiply completes here.
               if (fast_pend_q) begin
                  hi_q   <= res_hi;
                  lo_q   <= res_lo;
                  done_q <= 1'b1;
               end
               fast_pend_q <= fast_go;
               if (bus.start) begin
                  // Start has priority; a simultaneous MTHI/MTLO is dropped.
                  op_q    <= bus.op;
                  neg_a_q <= start_signed & bus.a[WIDTH-1];
                  neg_b_q <= start_signed & bus.b[WIDTH-1];
                  a_q     <= a_mag;
                  b_q     <= b_mag;
                  acc_q   <= '0;
                  cnt_q   <= CNT_LAST;
               end else if (!fast_pend_q) begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q - CW'(1);
               if (op_is_div(op_q)) begin
                  acc_q <= {step_rem, acc_q[WIDTH-2:0], step_q};
               end else begin
                  acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
               end
            end
            ST_FIXUP: begin
               hi_q       <= res_hi;
               lo_q       <= res_lo;
               done_q     <= 1'b1;
               div_zero_q <= res_dz;
            end
            default: ;
         endcase
      end
   end

   // Output drive.
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: self-checking bench for mips_muldiv. Results are compared
// against an arithmetic reference model; latency and busy length are checked
// for every operation. Handles both the default and the fast-multiply build.
module tb_mips_muldiv;
   import mips_pkg::*;

   localparam int W = 32;

`ifdef MIPS_MULDIV_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   // Architectural HI/LO as the bench expects them to be.
   logic [W-1:0] model_hi = '0;
   logic [W-1:0] model_lo = '0;

   always #5 clk = ~clk;

   mips_muldiv_if #(.WIDTH(W)) bus ();

   mips_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model from the instruction definitions.
   function automatic void model(input muldiv_op_t op, input logic [W-1:0] a, b,
                                 output logic [W-1:0] hi, lo, output logic dz);
      longint      sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      hi = '0;
      lo = '0;
      case (op)
         OP_MULT:  begin p = sa * sb; {hi, lo} = p; end
         OP_MULTU: begin up = 64'(a) * 64'(b); {hi, lo} = up; end
         OP_DIV: begin
            if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
            else begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
         end
         default: begin
            if (b == 0) begin lo = '1; hi = a; dz = 1'b1; end
            else begin lo = a / b; hi = a % b; end
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Issue one operation at the current negedge and follow it to done.
   // With interfere set, start/MTHI/MTLO junk is driven while the unit is busy.
   task automatic run_op(input muldiv_op_t op, input logic [W-1:0] a, b,
                         input bit interfere, input string name);
      logic [W-1:0] eh, el;
      logic         ed;
      int           k, busy_cnt, exp_lat, exp_busy;
      model(op, a, b, eh, el, ed);
      exp_lat  = (FAST && !op_is_div(op)) ? 1 : W + 1;
      exp_busy = (exp_lat == 1) ? 0 : W + 1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      k         = 0;
      busy_cnt  = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            bus.op    = muldiv_op_t'($urandom_range(0, 3));
            bus.a     = $urandom;
            bus.b     = $urandom;
         end
         if (interfere) begin
            bus.start = (k >= 3 && k <= W + 1);
            bus.hi_we = (k >= 3 && k <= W + 1);
            bus.lo_we = (k >= 3 && k <= W + 1) && k[0];
            bus.wdata = $urandom;
         end
         if (bus.busy) busy_cnt++;
      end while (!bus.done && k < 4 * W);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: done not seen within %0d cycles", name, k);
      end else begin
         checks++;
         if ((k - 1) !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, k - 1, exp_lat);
         end
         checks++;
         if (busy_cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
         end
         checks++;
         if (bus.hi !== eh) begin
            errors++;
            $display("FAIL %s hi: got %h expected %h", name, bus.hi, eh);
         end
         checks++;
         if (bus.lo !== el) begin
            errors++;
            $display("FAIL %s lo: got %h expected %h", name, bus.lo, el);
         end
         checks++;
         if (bus.div_zero !== ed) begin
            errors++;
            $display("FAIL %s div_zero: got %b expected %b", name, bus.div_zero, ed);
         end
      end
      model_hi = eh;
      model_lo = el;
   endtask

   // One idle cycle: unit must be quiet and HI/LO must hold.
   task automatic check_idle(input string name);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
         errors++;
         $display("FAIL %s idle flags: got busy=%b done=%b dz=%b expected 0 0 0",
                  name, bus.busy, bus.done, bus.div_zero);
      end
      checks++;
      if (bus.hi !== model_hi || bus.lo !== model_lo) begin
         errors++;
         $display("FAIL %s idle hold: got %h_%h expected %h_%h",
                  name, bus.hi, bus.lo, model_hi, model_lo);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset flags: got busy=%b done=%b dz=%b expected 0 0 0",
                  bus.busy, bus.done, bus.div_zero);
      end
      checks++;
      if (bus.hi !== '0 || bus.lo !== '0) begin
         errors++;
         $display("FAIL reset hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
      run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0, "mult_neg3x7");
      run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, "mult_min_sq");
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, "div_neg7_2");
      run_op(OP_DIVU,  32'd7,         32'd2,         1'b0, "divu_7_2");
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
      run_op(OP_DIVU,  32'd5,         32'd0,         1'b0, "divu_by_zero");
      run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0,         1'b0, "div_by_zero_neg");
      check_idle("after_directed");
   endtask

   task automatic test_mt();
      logic [W-1:0] d;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0000_1234;
      @(negedge clk);
      bus.lo_we = 1'b0;
      model_lo  = 32'h0000_1234;
      checks++;
      if (bus.lo !== model_lo || bus.hi !== model_hi) begin
         errors++;
         $display("FAIL mtlo: got %h_%h expected %h_%h", bus.hi, bus.lo, model_hi, model_lo);
      end
      d = $urandom;
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = d;
      @(negedge clk);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      model_hi  = d;
      model_lo  = d;
      checks++;
      if (bus.hi !== d || bus.lo !== d) begin
         errors++;
         $display("FAIL mthi_mtlo: got %h_%h expected %h_%h", bus.hi, bus.lo, d, d);
      end
      check_idle("after_mt");
   endtask

   task automatic test_busy_ignore();
      run_op(OP_DIV,  $urandom, 32'($urandom_range(1, 1000)), 1'b1, "busy_ignore_div");
      run_op(OP_DIVU, $urandom, $urandom,                     1'b1, "busy_ignore_divu");
      check_idle("after_busy_ignore");
   endtask

   task automatic test_start_with_write();
      bus.lo_we = 1'b1;
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      run_op(OP_MULTU, 32'd1000, 32'd3000, 1'b0, "start_wins_mult");
      bus.lo_we = 1'b1;
      bus.wdata = 32'hCAFE_F00D;
      run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "start_wins_div");
      check_idle("after_start_wins");
   endtask

   task automatic test_reset_mid();
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'hFFFF_0000;
      bus.b     = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid flags: got busy=%b done=%b dz=%b expected 0 0 0",
                  bus.busy, bus.done, bus.div_zero);
      end
      checks++;
      if (bus.hi !== '0 || bus.lo !== '0) begin
         errors++;
         $display("FAIL reset_mid hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
      end
      reset    = 1'b0;
      model_hi = '0;
      model_lo = '0;
      check_idle("reset_mid_idle");
      run_op(OP_MULTU, 32'd3, 32'd5, 1'b0, "after_reset_multu");
   endtask

   // Random operations issued back to back, each in the done cycle of the last.
   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) begin
         run_op(muldiv_op_t'($urandom_range(0, 3)), pick(), pick(), 1'b0,
                $sformatf("rand%0d", i));
      end
      check_idle("after_random");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mt();
      test_busy_ignore();
      test_start_with_write();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Overall time bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
